uart_8250_wb_initiator: RTL and testbench

Wishbone classic single-cycle bus initiator that drives the 8-bit register file of the `uart_8250` responder. It accepts byte-wide register read/write requests from a local controller over a valid/ready port. For each request it issues one Wishbone cycle, then returns read data or an error on a one-cycle response strobe. It sits between a firmware-less controller (boot/console sequencer) and the UART's Wishbone slave port.

---
 rtl/uart_8250_pkg.sv | 24 ++
 rtl/uart_8250_wb_initiator.sv | 154 +++++++++++++++
 tb/tb_uart_8250_wb_initiator.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_8250_pkg.sv
// Shared definitions for the uart_8250 register file: register indices, LSR bit
// positions and the bus-initiator state encoding.
package uart_8250_pkg;

  localparam logic [2:0] RBR_THR_DLL = 3'd0;
  localparam logic [2:0] IER_DLM     = 3'd1;
  localparam logic [2:0] IIR_FCR     = 3'd2;
  localparam logic [2:0] LCR         = 3'd3;
  localparam logic [2:0] MCR         = 3'd4;
  localparam logic [2:0] LSR         = 3'd5;
  localparam logic [2:0] MSR         = 3'd6;
  localparam logic [2:0] SCR         = 3'd7;

  localparam int unsigned LSR_DR   = 32'd0;
  localparam int unsigned LSR_THRE = 32'd5;
  localparam int unsigned LSR_TEMT = 32'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/uart_8250_wb_initiator.sv
// Wishbone classic initiator for the uart_8250 register file: one bus cycle per
// request, answered by a one-cycle response strobe carrying read data or a timeout.
module uart_8250_wb_initiator
  import uart_8250_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned REG_SHIFT = 32'd2,
  parameter int unsigned TIMEOUT   = 32'd255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_reg,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I
);

  localparam int unsigned      CNT_W      = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 32'd1);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 32'd0);

  wb_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      adr_r, adr_s;
  logic [31:0]      dat_r, dat_s;
  logic             we_r, we_s;
  logic [3:0]       sel_r, sel_s;
  logic             cyc_r, cyc_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic [7:0]       rsp_rdata_r, rsp_rdata_s;
  logic             rsp_err_r, rsp_err_s;

  logic [31:0]      req_adr_s;
  logic [7:0]       ack_byte_s;
  logic             expire_s;

  assign req_adr_s  = BASE_ADDR + (32'(req_reg) << REG_SHIFT);
  // The lane is taken from the held address, so the byte picked matches SEL_O.
  assign ack_byte_s = 8'(DAT_I >> {adr_r[1:0], 3'b000});
  assign expire_s   = TIMEOUT_EN && (cnt_r == CNT_LAST);

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign ADR_O     = adr_r;
  assign DAT_O     = dat_r;
  assign WE_O      = we_r;
  assign SEL_O     = sel_r;
  assign STB_O     = cyc_r;
  assign CYC_O     = cyc_r;

  // Next-state and next-output logic for the request/bus/response sequence.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    we_s        = we_r;
    sel_s       = sel_r;
    cyc_s       = cyc_r;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = 8'h00;
    rsp_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = BUS;
          cnt_s   = '0;
          adr_s   = req_adr_s;
          dat_s   = {4{req_wdata}};
          we_s    = req_we;
          sel_s   = 4'b0001 << req_adr_s[1:0];
          cyc_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        // An ACK arriving on the expiry cycle still completes normally.
        if (ACK_I) begin
          state_s     = RESP;
          cyc_s       = 1'b0;
          we_s        = 1'b0;
          sel_s       = 4'b0000;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = we_r ? 8'h00 : ack_byte_s;
        end else if (expire_s) begin
          state_s     = RESP;
          cyc_s       = 1'b0;
          we_s        = 1'b0;
          sel_s       = 4'b0000;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
        end else begin
          if (TIMEOUT_EN) begin
            cnt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_s = cnt_r;
          end
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cyc_s   = 1'b0;
        we_s    = 1'b0;
        sel_s   = 4'b0000;
      end
    endcase
  end

  // State and registered bus/response outputs.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      adr_r       <= 32'h0000_0000;
      dat_r       <= 32'h0000_0000;
      we_r        <= 1'b0;
      sel_r       <= 4'b0000;
      cyc_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      we_r        <= we_s;
      sel_r       <= sel_s;
      cyc_r       <= cyc_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_uart_8250_wb_initiator.sv
// Bench for uart_8250_wb_initiator: three instances (stride 4, stride 1, short timeout)
// checked every cycle against a transaction-timeline model plus literal expectations.
module tb_uart_8250_wb_initiator;
  import uart_8250_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  function automatic int unsigned shift_of(input int i);
    return (i == 1) ? 32'd0 : 32'd2;
  endfunction

  function automatic int unsigned to_of(input int i);
    return (i == 2) ? 32'd4 : 32'd255;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [2:0]       we_o, stb_o, cyc_o, ack;
  logic [2:0][2:0]  req_reg;
  logic [2:0][7:0]  req_wdata, rsp_rdata;
  logic [2:0][31:0] adr_o, dat_o, dat_i;
  logic [2:0][3:0]  sel_o;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_8250_wb_initiator #(
      .BASE_ADDR(BASE),
      .REG_SHIFT(shift_of(g)),
      .TIMEOUT  (to_of(g))
    ) u_dut (
      .CLK_I    (clk),
      .RST_I    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_reg  (req_reg[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .ADR_O    (adr_o[g]),
      .DAT_O    (dat_o[g]),
      .DAT_I    (dat_i[g]),
      .WE_O     (we_o[g]),
      .SEL_O    (sel_o[g]),
      .STB_O    (stb_o[g]),
      .CYC_O    (cyc_o[g]),
      .ACK_I    (ack[g])
    );
  end

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model: one transaction per instance, described by its accept and end edges.
  bit          m_active   [3];
  int          m_acc      [3];
  int          m_end      [3];
  logic [31:0] m_cur_adr  [3];
  logic [31:0] m_prev_adr [3];
  logic [31:0] m_cur_dat  [3];
  logic [31:0] m_prev_dat [3];
  logic        m_we       [3];
  logic [3:0]  m_sel      [3];
  logic [7:0]  m_rd       [3];
  logic        m_err      [3];

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      m_active[i]   = 1'b0;
      m_acc[i]      = 0;
      m_end[i]      = 0;
      m_cur_adr[i]  = 32'h0;
      m_prev_adr[i] = 32'h0;
      m_cur_dat[i]  = 32'h0;
      m_prev_dat[i] = 32'h0;
      m_we[i]       = 1'b0;
      m_sel[i]      = 4'b0000;
      m_rd[i]       = 8'h00;
      m_err[i]      = 1'b0;
    end
  endtask

  task automatic model_start(input int i, input logic we, input logic [2:0] rg,
                             input logic [7:0] wd, input int k, input logic [31:0] d);
    logic [31:0] a;
    bit          tmo;
    int          acc;
    acc = cyc + 1;
    if (m_active[i] && acc < m_end[i] + 2) acc = m_end[i] + 2;
    tmo = (to_of(i) != 0) && (k == 0 || k > int'(to_of(i)));
    a   = BASE + (32'(rg) << shift_of(i));
    m_prev_adr[i] = m_cur_adr[i];
    m_prev_dat[i] = m_cur_dat[i];
    m_cur_adr[i]  = a;
    m_cur_dat[i]  = {4{wd}};
    m_we[i]       = we;
    m_sel[i]      = 4'b0001 << a[1:0];
    m_rd[i]       = (we || tmo) ? 8'h00 : 8'(d >> (32'd8 * 32'(a[1:0])));
    m_err[i]      = tmo;
    m_acc[i]      = acc;
    m_end[i]      = tmo ? acc + int'(to_of(i)) : acc + k;
    m_active[i]   = 1'b1;
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] cyc %0d: got 0x%08h, want 0x%08h", nm, i, cyc, act, exp);
  endtask

  // Per-cycle comparison of every instance against the timeline model.
  bit e_bus, e_rsp, e_rdy, e_new;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      e_bus = m_active[i] && (cyc >= m_acc[i]) && (cyc < m_end[i]);
      e_rsp = m_active[i] && (cyc == m_end[i]);
      e_rdy = !(m_active[i] && (cyc >= m_acc[i]) && (cyc <= m_end[i]));
      e_new = m_active[i] && (cyc >= m_acc[i]);
      chk("stb", i, 32'(stb_o[i]), 32'(e_bus));
      chk("cyc", i, 32'(cyc_o[i]), 32'(e_bus));
      chk("req_ready", i, 32'(req_ready[i]), 32'(e_rdy));
      chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(e_rsp));
      chk("adr", i, adr_o[i], e_new ? m_cur_adr[i] : m_prev_adr[i]);
      chk("dat", i, dat_o[i], e_new ? m_cur_dat[i] : m_prev_dat[i]);
      chk("we", i, 32'(we_o[i]), e_bus ? 32'(m_we[i]) : 32'h0);
      chk("sel", i, 32'(sel_o[i]), e_bus ? 32'(m_sel[i]) : 32'h0);
      if (e_rsp) begin
        chk("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(m_rd[i]));
        chk("rsp_err", i, 32'(rsp_err[i]), 32'(m_err[i]));
      end
    end
  end

  // Activity counters observed from the DUT pins.
  int stb_cnt [3] = '{0, 0, 0};
  int rsp_cnt [3] = '{0, 0, 0};
  int rise_edge [3] = '{0, 0, 0};
  int rsp_edge [3] = '{0, 0, 0};
  bit stb_prev [3] = '{1'b0, 1'b0, 1'b0};
  bit rv_prev [3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (stb_o[i] === 1'b1) stb_cnt[i] <= stb_cnt[i] + 1;
      if (stb_o[i] === 1'b1 && !stb_prev[i]) rise_edge[i] <= cyc;
      if (rsp_valid[i] === 1'b1) rsp_cnt[i] <= rsp_cnt[i] + 1;
      if (rsp_valid[i] === 1'b1 && !rv_prev[i]) rsp_edge[i] <= cyc;
      stb_prev[i] <= (stb_o[i] === 1'b1);
      rv_prev[i]  <= (rsp_valid[i] === 1'b1);
    end
  end

  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] o_adr, o_dat;
  logic [3:0]  o_sel;
  logic        o_we, o_rv, o_err;
  logic [7:0]  o_rd;

  // One request; k = ACK latency in cycles after accept, 0 = never acknowledged.
  task automatic run(input int i, input logic we, input logic [2:0] rg, input logic [7:0] wd,
                     input int k, input logic [31:0] d, input bit hold);
    model_start(i, we, rg, wd, k, d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_reg[i]   = rg;
    req_wdata[i] = wd;
    wait_edge(m_acc[i]);
    if (!hold) req_valid[i] = 1'b0;
    o_adr = adr_o[i];
    o_dat = dat_o[i];
    o_sel = sel_o[i];
    o_we  = we_o[i];
    if (k != 0) begin
      wait_edge(m_acc[i] + k - 1);
      ack[i]   = 1'b1;
      dat_i[i] = d;
    end
    wait_edge(m_end[i]);
    ack[i]   = 1'b0;
    dat_i[i] = 32'hFFFF_FFFF;
    o_rv  = rsp_valid[i];
    o_rd  = rsp_rdata[i];
    o_err = rsp_err[i];
    wait_edge(m_end[i] + 1);
  endtask

  int snap, snap2;

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b000;
    req_we    = 3'b000;
    ack       = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req_reg[i]   = 3'd0;
      req_wdata[i] = 8'h00;
      dat_i[i]     = 32'hFFFF_FFFF;
    end
    reset_model();
    @(posedge clk);
    #1;
    wait_edge(3);
    chk("rst_ready", 0, 32'(req_ready[0]), 32'h1);
    chk("rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'h0);
    chk("rst_rdata", 0, 32'(rsp_rdata[0]), 32'h0);
    chk("rst_stb", 0, 32'(stb_o[0]), 32'h0);
    chk("rst_adr", 0, adr_o[0], 32'h0);
    chk("rst_sel", 0, 32'(sel_o[0]), 32'h0);
    rst_n = 1'b1;
    wait_edge(cyc + 1);

    // LCR write, stride 4
    run(0, 1'b1, LCR, 8'h83, 1, 32'h0, 1'b0);
    chk("lcr_adr", 0, o_adr, 32'h1000_000C);
    chk("lcr_sel", 0, 32'(o_sel), 32'h1);
    chk("lcr_dat", 0, o_dat, 32'h8383_8383);
    chk("lcr_we", 0, 32'(o_we), 32'h1);
    chk("lcr_rv", 0, 32'(o_rv), 32'h1);
    chk("lcr_err", 0, 32'(o_err), 32'h0);
    chk("lcr_rd", 0, 32'(o_rd), 32'h0);

    // LSR read, stride 4, responder latency 2
    run(0, 1'b0, LSR, 8'h00, 2, 32'h0000_0060, 1'b0);
    chk("lsr_adr", 0, o_adr, 32'h1000_0014);
    chk("lsr_rd", 0, 32'(o_rd), 32'h60);
    chk("lsr_rsp_after_accept", 0, 32'(rsp_edge[0] + 1 - rise_edge[0]), 32'd3);

    // LSR read and lane-3 read, stride 1
    run(1, 1'b0, LSR, 8'h00, 1, 32'h0000_A500, 1'b0);
    chk("s1_lsr_adr", 1, o_adr, 32'h1000_0005);
    chk("s1_lsr_sel", 1, 32'(o_sel), 32'h2);
    chk("s1_lsr_rd", 1, 32'(o_rd), 32'hA5);
    run(1, 1'b0, LCR, 8'h00, 3, 32'hC300_0000, 1'b0);
    chk("s1_lcr_sel", 1, 32'(o_sel), 32'h8);
    chk("s1_lcr_rd", 1, 32'(o_rd), 32'hC3);

    // Timeout of 4 with no ACK, then a late ACK
    snap = stb_cnt[2];
    run(2, 1'b0, IER_DLM, 8'h00, 0, 32'h0, 1'b0);
    chk("to_stb_cycles", 2, 32'(stb_cnt[2] - snap), 32'd4);
    chk("to_rv", 2, 32'(o_rv), 32'h1);
    chk("to_err", 2, 32'(o_err), 32'h1);
    chk("to_rd", 2, 32'(o_rd), 32'h0);
    snap  = rsp_cnt[2];
    snap2 = stb_cnt[2];
    ack[2]   = 1'b1;
    dat_i[2] = 32'h0000_00EE;
    wait_edge(cyc + 1);
    ack[2] = 1'b0;
    wait_edge(cyc + 2);
    chk("late_ack_rsp", 2, 32'(rsp_cnt[2] - snap), 32'd0);
    chk("late_ack_stb", 2, 32'(stb_cnt[2] - snap2), 32'd0);
    chk("late_ack_ready", 2, 32'(req_ready[2]), 32'h1);

    // ACK on the expiry cycle wins
    run(2, 1'b0, SCR, 8'h00, 4, 32'h1234_5677, 1'b0);
    chk("exp_ack_err", 2, 32'(o_err), 32'h0);
    chk("exp_ack_rd", 2, 32'(o_rd), 32'h77);

    // Stray ACK in IDLE, then back-to-back write/read with req_valid held
    snap  = rsp_cnt[0];
    snap2 = stb_cnt[0];
    ack[0]   = 1'b1;
    dat_i[0] = 32'h1234_5678;
    wait_edge(cyc + 1);
    ack[0] = 1'b0;
    wait_edge(cyc + 2);
    chk("idle_ack_rsp", 0, 32'(rsp_cnt[0] - snap), 32'd0);
    chk("idle_ack_stb", 0, 32'(stb_cnt[0] - snap2), 32'd0);
    run(0, 1'b1, SCR, 8'h5A, 1, 32'h0, 1'b1);
    snap = rise_edge[0];
    chk("b2b_wr_rv", 0, 32'(o_rv), 32'h1);
    run(0, 1'b0, SCR, 8'h00, 1, 32'h0000_005A, 1'b0);
    chk("b2b_spacing", 0, 32'(rise_edge[0] - snap), 32'd3);
    chk("b2b_rd", 0, 32'(o_rd), 32'h5A);
    chk("b2b_rd_adr", 0, o_adr, 32'h1000_001C);

    // Reset while the bus cycle is open
    model_start(0, 1'b1, MCR, 8'h11, 0, 32'h0);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_reg[0]   = MCR;
    req_wdata[0] = 8'h11;
    wait_edge(m_acc[0]);
    req_valid[0] = 1'b0;
    wait_edge(m_acc[0] + 2);
    #2;
    chk("pre_rst_stb", 0, 32'(stb_o[0]), 32'h1);
    snap  = rsp_cnt[0];
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("arst_stb", 0, 32'(stb_o[0]), 32'h0);
    chk("arst_cyc", 0, 32'(cyc_o[0]), 32'h0);
    chk("arst_ready", 0, 32'(req_ready[0]), 32'h1);
    chk("arst_adr", 0, adr_o[0], 32'h0);
    chk("arst_dat", 0, dat_o[0], 32'h0);
    chk("arst_we_sel", 0, {27'h0, we_o[0], sel_o[0]}, 32'h0);
    wait_edge(cyc + 2);
    rst_n = 1'b1;
    wait_edge(cyc + 6);
    chk("post_rst_no_rsp", 0, 32'(rsp_cnt[0] - snap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
